// File: rtl/ad_pack_pkg.sv
// Shared types and sizing helpers for the ad_pack narrow-to-wide unit packer.
package ad_pack_pkg;

  typedef enum logic [0:0] {
    ACC   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  function automatic int unsigned gcd(input int unsigned a, input int unsigned b);
    int unsigned x;
    int unsigned y;
    int unsigned t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Units needed to hold a leftover partial word plus one full input word.
  function automatic int unsigned acc_units(input int unsigned i_w, input int unsigned o_w);
    return o_w + i_w - gcd(i_w, o_w);
  endfunction

  function automatic int unsigned fill_width(input int unsigned o_w);
    return (o_w > 1) ? $clog2(o_w) : 1;
  endfunction

endpackage

// File: rtl/ad_pack_oreg.sv
// Output stage for ad_pack: registered (latency 1) or pass-through (latency 0).
module ad_pack_oreg #(
  parameter int unsigned DW    = 32,
  parameter int unsigned O_REG = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] data_i,
  input  logic          valid_i,
  input  logic          last_i,
  output logic [DW-1:0] data_o,
  output logic          valid_o,
  output logic          last_o
);

  generate
    if (O_REG != 0) begin : g_reg
      logic [DW-1:0] data_q;
      logic          valid_q;
      logic          last_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          data_q  <= '0;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
        end else begin
          data_q  <= data_i;
          valid_q <= valid_i;
          last_q  <= last_i;
        end
      end

      assign data_o  = data_q;
      assign valid_o = valid_q;
      assign last_o  = last_q;
    end else begin : g_comb
      logic unused_clk;
      assign unused_clk = clk;
      // Outputs still read zero while reset is held.
      assign data_o  = reset ? '0 : data_i;
      assign valid_o = valid_i & ~reset;
      assign last_o  = last_i & ~reset;
    end
  endgenerate

endmodule

// File: rtl/ad_pack.sv
// Packs I_W-unit input words into O_W-unit output words, unit 0 first.
// Optional packet-end flush with zero padding is enabled by AD_PACK_FLUSH_EN.
module ad_pack
  import ad_pack_pkg::*;
#(
  parameter int unsigned I_W    = 3,
  parameter int unsigned O_W    = 4,
  parameter int unsigned UNIT_W = 8,
  parameter int unsigned O_REG  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [I_W*UNIT_W-1:0] idata,
  input  logic                  ivalid,
  input  logic                  ilast,
  output logic                  iready,
  output logic [O_W*UNIT_W-1:0] odata,
  output logic                  ovalid,
  output logic                  olast
);

  localparam int unsigned ACC_W  = acc_units(I_W, O_W) * UNIT_W;
  localparam int unsigned OD_W   = O_W * UNIT_W;
  localparam int unsigned FILL_W = fill_width(O_W);
  localparam int unsigned NF_W   = $clog2(O_W + I_W) + 1;

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [ACC_W-1:0]  comb_c;
  logic [ACC_W-1:0]  rest_c;
  logic [NF_W-1:0]   nfill_c;
  logic              accept_c;
  logic [OD_W-1:0]   out_data_c;
  logic              out_valid_c;
  logic              out_last_c;

`ifdef AD_PACK_FLUSH_EN
  state_e state_q, state_d;
  assign iready = (state_q == ACC);
`else
  logic unused_ilast;
  assign unused_ilast = ilast;
  assign iready = 1'b1;
`endif

  assign accept_c = ivalid & iready;
  assign nfill_c  = NF_W'(fill_q) + NF_W'(I_W);
  assign comb_c   = acc_q | (ACC_W'(idata) << (32'(fill_q) * UNIT_W));
  // Units left over once a full output word has been taken off the bottom.
  assign rest_c   = ACC_W'({{OD_W{1'b0}}, comb_c} >> OD_W);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q  <= '0;
      fill_q <= '0;
    end else begin
      acc_q  <= acc_d;
      fill_q <= fill_d;
    end
  end

`ifdef AD_PACK_FLUSH_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ACC;
    else       state_q <= state_d;
  end
`endif

  // Next state for the accumulator, fill level and (optional) flush FSM.
  always_comb begin
    acc_d  = acc_q;
    fill_d = fill_q;
`ifdef AD_PACK_FLUSH_EN
    state_d = state_q;
    if (state_q == FLUSH) begin
      acc_d   = '0;
      fill_d  = '0;
      state_d = ACC;
    end else if (accept_c && ilast) begin
      if (nfill_c > NF_W'(O_W)) begin
        acc_d   = rest_c;
        fill_d  = FILL_W'(nfill_c - NF_W'(O_W));
        state_d = FLUSH;
      end else begin
        acc_d  = '0;
        fill_d = '0;
      end
    end else
`endif
    if (accept_c) begin
      if (nfill_c >= NF_W'(O_W)) begin
        acc_d  = rest_c;
        fill_d = FILL_W'(nfill_c - NF_W'(O_W));
      end else begin
        acc_d  = comb_c;
        fill_d = FILL_W'(nfill_c);
      end
    end
  end

  // Output word selection; unfilled units are already zero so no masking is needed.
  always_comb begin
    out_data_c  = '0;
    out_valid_c = 1'b0;
    out_last_c  = 1'b0;
`ifdef AD_PACK_FLUSH_EN
    if (state_q == FLUSH) begin
      out_data_c  = acc_q[OD_W-1:0];
      out_valid_c = 1'b1;
      out_last_c  = 1'b1;
    end else if (accept_c && ilast) begin
      out_data_c  = comb_c[OD_W-1:0];
      out_valid_c = 1'b1;
      out_last_c  = (nfill_c <= NF_W'(O_W));
    end else
`endif
    if (accept_c && (nfill_c >= NF_W'(O_W))) begin
      out_data_c  = comb_c[OD_W-1:0];
      out_valid_c = 1'b1;
    end
  end

  ad_pack_oreg #(
    .DW    (OD_W),
    .O_REG (O_REG)
  ) u_oreg (
    .clk     (clk),
    .reset   (reset),
    .data_i  (out_data_c),
    .valid_i (out_valid_c),
    .last_i  (out_last_c),
    .data_o  (odata),
    .valid_o (ovalid),
    .last_o  (olast)
  );

endmodule

// File: tb/tb_ad_pack.sv
// Self-checking bench for ad_pack: a 3->4 registered instance and a 2->4 combinational
// instance, both checked every cycle against a unit-queue reference model.
`timescale 1ns/1ps
module tb_ad_pack;

  typedef logic [7:0] unit_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic [23:0] d34 = '0;
  logic        v34 = 1'b0, l34 = 1'b0;
  logic        rdy34, ov34, ol34;
  logic [31:0] o34;

  logic [15:0] d24 = '0;
  logic        v24 = 1'b0, l24 = 1'b0;
  logic        rdy24, ov24, ol24;
  logic [31:0] o24;

  int n_tests = 0;
  int n_fail  = 0;

  unit_t       q34[$];
  unit_t       q24[$];
  bit          fl34 = 1'b0, fl24 = 1'b0;
  logic [32:0] got34[$];
  logic [32:0] got24[$];

  always #5 clk = ~clk;

  ad_pack #(.I_W(3), .O_W(4), .UNIT_W(8), .O_REG(1)) u_dut34 (
    .clk(clk), .reset(reset), .idata(d34), .ivalid(v34), .ilast(l34),
    .iready(rdy34), .odata(o34), .ovalid(ov34), .olast(ol34)
  );

  ad_pack #(.I_W(2), .O_W(4), .UNIT_W(8), .O_REG(0)) u_dut24 (
    .clk(clk), .reset(reset), .idata(d24), .ivalid(v24), .ilast(l24),
    .iready(rdy24), .odata(o24), .ovalid(ov24), .olast(ol24)
  );

  // Reference: a FIFO of units; whole O_W groups leave from the front.
  task automatic model_step(input int iw, input int ow, ref unit_t q[$], inout bit fl,
                            input bit v, input logic [31:0] d, input bit l,
                            output bit ev, output logic [31:0] ed, output bit el);
    ev = 1'b0;
    ed = '0;
    el = 1'b0;
    if (fl) begin
      ev = 1'b1;
      el = 1'b1;
      for (int k = 0; k < ow; k++) if (k < q.size()) ed[k*8 +: 8] = q[k];
      q.delete();
      fl = 1'b0;
    end else if (v) begin
      for (int k = 0; k < iw; k++) q.push_back(d[k*8 +: 8]);
`ifdef AD_PACK_FLUSH_EN
      if (l) begin
        ev = 1'b1;
        for (int k = 0; k < ow; k++) if (k < q.size()) ed[k*8 +: 8] = q[k];
        if (q.size() <= ow) begin
          el = 1'b1;
          q.delete();
        end else begin
          for (int k = 0; k < ow; k++) void'(q.pop_front());
          fl = 1'b1;
        end
      end else
`else
      if (l) ev = 1'b0;
`endif
      if (q.size() >= ow) begin
        ev = 1'b1;
        for (int k = 0; k < ow; k++) ed[k*8 +: 8] = q.pop_front();
      end
    end
  endtask

  // One clock cycle: inputs already driven; returns 1 time unit after the next rising edge.
  task automatic tick();
    bit          ev2, el2, ev3, el3;
    logic [31:0] ed2, ed3;
    #1;
    n_tests++;
    if (rdy24 !== !fl24) begin
      n_fail++;
      $display("FAIL iready24: got %b want %b at %0t", rdy24, !fl24, $time);
    end
    n_tests++;
    if (rdy34 !== !fl34) begin
      n_fail++;
      $display("FAIL iready34: got %b want %b at %0t", rdy34, !fl34, $time);
    end
    model_step(2, 4, q24, fl24, v24, {16'h0, d24}, l24, ev2, ed2, el2);
    n_tests++;
    if (ov24 !== ev2) begin
      n_fail++;
      $display("FAIL ovalid24: got %b want %b at %0t", ov24, ev2, $time);
    end else if (ev2) begin
      n_tests++;
      if (o24 !== ed2 || ol24 !== el2) begin
        n_fail++;
        $display("FAIL word24: got %h/%b want %h/%b at %0t", o24, ol24, ed2, el2, $time);
      end
      got24.push_back({ol24, o24});
    end
    model_step(3, 4, q34, fl34, v34, {8'h0, d34}, l34, ev3, ed3, el3);
    @(posedge clk);
    #1;
    n_tests++;
    if (ov34 !== ev3) begin
      n_fail++;
      $display("FAIL ovalid34: got %b want %b at %0t", ov34, ev3, $time);
    end else if (ev3) begin
      n_tests++;
      if (o34 !== ed3 || ol34 !== el3) begin
        n_fail++;
        $display("FAIL word34: got %h/%b want %h/%b at %0t", o34, ol34, ed3, el3, $time);
      end
      got34.push_back({ol34, o34});
    end
  endtask

  task automatic check_got34(input int idx, input logic [32:0] want);
    n_tests++;
    if (idx >= got34.size()) begin
      n_fail++;
      $display("FAIL got34[%0d]: missing word, want %h", idx, want);
    end else if (got34[idx] !== want) begin
      n_fail++;
      $display("FAIL got34[%0d]: got %h want %h", idx, got34[idx], want);
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if ({ov34, ol34, o34, ov24, ol24, o24} !== '0 || rdy34 !== 1'b1 || rdy24 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset: got o34=%h ov=%b ol=%b o24=%h rdy=%b%b want zeros, rdy=11",
               o34, ov34, ol34, o24, rdy34, rdy24);
    end
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    got34.delete();
    v34 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d34 = {8'(3*i+2), 8'(3*i+1), 8'(3*i)};
      tick();
    end
    v34 = 1'b0;
    tick();
    check_got34(0, {1'b0, 32'h03020100});
    check_got34(1, {1'b0, 32'h07060504});
    check_got34(2, {1'b0, 32'h0B0A0908});
  endtask

  task automatic test_gapped();
    got24.delete();
    for (int i = 0; i < 16; i++) begin
      v24 = (i % 2 == 0);
      d24 = 16'($urandom);
      tick();
    end
    v24 = 1'b0;
    tick();
    n_tests++;
    if (got24.size() != 4) begin
      n_fail++;
      $display("FAIL gapped_count: got %0d words want 4", got24.size());
    end
  endtask

  task automatic test_reset_mid();
    got34.delete();
    v34 = 1'b1;
    d34 = 24'h020100; tick();
    d34 = 24'h050403; tick();
    v34 = 1'b0;
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if (ov34 !== 1'b0 || o34 !== '0 || ol34 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got %h/%b/%b want 0/0/0", o34, ov34, ol34);
    end
    q34.delete();
    q24.delete();
    fl34 = 1'b0;
    fl24 = 1'b0;
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
    got34.delete();
    v34 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d34 = {8'(3*i+2), 8'(3*i+1), 8'(3*i)};
      tick();
    end
    v34 = 1'b0;
    tick();
    check_got34(0, {1'b0, 32'h03020100});
  endtask

`ifdef AD_PACK_FLUSH_EN
  task automatic test_flush_split();
    got34.delete();
    v34 = 1'b1;
    l34 = 1'b0; d34 = 24'h020100; tick();
    l34 = 1'b1; d34 = 24'h050403; tick();
    l34 = 1'b0; d34 = 24'hEEDDCC; tick();
    d34 = 24'h020100; tick();
    d34 = 24'h050403; tick();
    l34 = 1'b1; d34 = 24'h080706; tick();
    l34 = 1'b0; v34 = 1'b0; tick();
    tick();
    check_got34(0, {1'b0, 32'h03020100});
    check_got34(1, {1'b1, 32'h00000504});
    check_got34(2, {1'b0, 32'h03020100});
    check_got34(3, {1'b0, 32'h07060504});
    check_got34(4, {1'b1, 32'h00000008});
  endtask

  task automatic test_flush_single();
    got34.delete();
    v34 = 1'b1; l34 = 1'b1; d34 = 24'hAABBCC; tick();
    v34 = 1'b0; l34 = 1'b0; tick();
    check_got34(0, {1'b1, 32'h00AABBCC});
    n_tests++;
    if (got34.size() != 1) begin
      n_fail++;
      $display("FAIL flush_single_count: got %0d words want 1", got34.size());
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      v34 = ($urandom % 4) != 0;
      d34 = 24'($urandom);
      l34 = ($urandom % 8) == 0;
      v24 = ($urandom % 4) != 0;
      d24 = 16'($urandom);
      l24 = ($urandom % 8) == 0;
      tick();
    end
    v34 = 1'b0; l34 = 1'b0; v24 = 1'b0; l24 = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_reset_mid();
`ifdef AD_PACK_FLUSH_EN
    test_flush_split();
    test_flush_single();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
